// File: rtl/onchip_mem_stream_loader_pkg.sv
// Shared types and constants for the on-chip memory stream loader.
// LOADER_READBACK_VERIFY_EN adds the VRD/VCMP readback states.
package onchip_loader_pkg;
   localparam int MEM_DEPTH  = 51200;
   localparam int MEM_ADDR_W = 16;
   localparam int MEM_DATA_W = 32;
   localparam int MEM_BE_W   = 4;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CHECK   = 3'd1,
      ST_COLLECT = 3'd2,
      ST_WRITE   = 3'd3,
      ST_FINISH  = 3'd4
`ifdef LOADER_READBACK_VERIFY_EN
      , ST_VRD   = 3'd5,
      ST_VCMP    = 3'd6
`endif
   } state_t;

   // Expand byte enables into a bit mask over the data word.
   function automatic logic [MEM_DATA_W-1:0] be_mask(input logic [MEM_BE_W-1:0] be);
      logic [MEM_DATA_W-1:0] m;
      m = '0;
      for (int k = 0; k < MEM_BE_W; k++) m[8*k +: 8] = {8{be[k]}};
      return m;
   endfunction
endpackage

// File: rtl/onchip_mem_stream_loader_if.sv
// Byte-stream and RAM slave-port bundle used by the loader.
interface onchip_mem_stream_loader_if #(parameter int ADDR_W = 16);
   logic [7:0]        st_data;
   logic              st_valid;
   logic              st_ready;
   logic [ADDR_W-1:0] mem_address;
   logic [3:0]        mem_byteenable;
   logic              mem_chipselect;
   logic              mem_write;
   logic [31:0]       mem_writedata;
   logic              mem_clken;
   logic [31:0]       mem_readdata;

   modport master (
      input  st_data, st_valid, mem_readdata,
      output st_ready, mem_address, mem_byteenable, mem_chipselect,
             mem_write, mem_writedata, mem_clken
   );

   modport slave (
      output st_data, st_valid, mem_readdata,
      input  st_ready, mem_address, mem_byteenable, mem_chipselect,
             mem_write, mem_writedata, mem_clken
   );
endinterface

// File: rtl/onchip_mem_stream_loader_byte_word_packer.sv
// Packs bytes little-endian into a 32-bit word and accumulates byte enables.
module byte_word_packer
   import onchip_loader_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clear,
   input  logic                  load,
   input  logic [7:0]            data,
   output logic [MEM_DATA_W-1:0] word,
   output logic [MEM_BE_W-1:0]   be,
   output logic                  full
);
   logic [1:0]            lane_d, lane_q;
   logic [MEM_DATA_W-1:0] word_d, word_q;
   logic [MEM_BE_W-1:0]   be_d, be_q;

   always_comb begin
      lane_d = lane_q;
      word_d = word_q;
      be_d   = be_q;
      if (clear) begin
         lane_d = '0;
         word_d = '0;
         be_d   = '0;
      end else if (load) begin
         word_d[{lane_q, 3'b000} +: 8] = data;
         be_d[lane_q]                  = 1'b1;
         lane_d                        = lane_q + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         lane_q <= '0;
         word_q <= '0;
         be_q   <= '0;
      end else begin
         lane_q <= lane_d;
         word_q <= word_d;
         be_q   <= be_d;
      end
   end

   assign word = word_q;
   assign be   = be_q;
   // The byte being loaded now completes the word.
   assign full = (lane_q == 2'd3);
endmodule

// File: rtl/onchip_mem_stream_loader.sv
// Streams bytes into consecutive words of the on-chip RAM from a base address.
// Define LOADER_READBACK_VERIFY_EN to read back and compare every written word.
module onchip_mem_stream_loader
   import onchip_loader_pkg::*;
#(
   parameter int ADDR_W = MEM_ADDR_W,
   parameter int DEPTH  = MEM_DEPTH,
   parameter int CNT_W  = 18
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  byte_count,
   output logic              busy,
   output logic              done,
   output logic              error,
   onchip_mem_stream_loader_if.master bus
);
   localparam logic [CNT_W+1:0] DEPTH_L = (CNT_W+2)'(DEPTH);

   state_t            state_d, state_q;
   logic [ADDR_W-1:0] addr_d, addr_q;
   logic [CNT_W-1:0]  rem_d, rem_q;
   logic              error_d, error_q;
   logic [CNT_W:0]    words;
   logic [CNT_W+1:0]  span;
   logic              xfer, pk_clear, pk_full;
   logic [MEM_DATA_W-1:0] pk_word;
   logic [MEM_BE_W-1:0]   pk_be;

   byte_word_packer u_packer (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (pk_clear),
      .load    (xfer),
      .data    (bus.st_data),
      .word    (pk_word),
      .be      (pk_be),
      .full    (pk_full)
   );

   // rem_q still holds the full byte count while in CHECK.
   assign words = ({1'b0, rem_q} + (CNT_W+1)'(3)) >> 2;
   assign span  = (CNT_W+2)'(addr_q) + (CNT_W+2)'(words);
   assign xfer  = bus.st_valid & bus.st_ready;

`ifdef LOADER_READBACK_VERIFY_EN
   logic rd_mismatch;
   assign rd_mismatch = ((bus.mem_readdata ^ pk_word) & be_mask(pk_be)) != '0;
`else
   logic unused_readdata;
   assign unused_readdata = ^bus.mem_readdata;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         error_q <= error_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      error_d = error_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               addr_d  = base_addr;
               rem_d   = byte_count;
               error_d = 1'b0;
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (rem_q == '0) begin
               state_d = ST_FINISH;
            end else if (span > DEPTH_L) begin
               error_d = 1'b1;
               state_d = ST_FINISH;
            end else begin
               state_d = ST_COLLECT;
            end
         end
         ST_COLLECT: begin
            if (xfer) begin
               rem_d = rem_q - CNT_W'(1);
               if (pk_full || rem_q == CNT_W'(1)) state_d = ST_WRITE;
            end
         end
`ifdef LOADER_READBACK_VERIFY_EN
         ST_WRITE: state_d = ST_VRD;
         ST_VRD:   state_d = ST_VCMP;
         ST_VCMP: begin
            if (rd_mismatch) begin
               error_d = 1'b1;
               state_d = ST_FINISH;
            end else begin
               addr_d  = addr_q + ADDR_W'(1);
               state_d = (rem_q == '0) ? ST_FINISH : ST_COLLECT;
            end
         end
`else
         ST_WRITE: begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = (rem_q == '0) ? ST_FINISH : ST_COLLECT;
         end
`endif
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy               = (state_q != ST_IDLE);
      done               = (state_q == ST_FINISH);
      bus.st_ready       = (state_q == ST_COLLECT);
      bus.mem_chipselect = (state_q == ST_WRITE);
      bus.mem_write      = (state_q == ST_WRITE);
`ifdef LOADER_READBACK_VERIFY_EN
      if (state_q == ST_VRD) bus.mem_chipselect = 1'b1;
      pk_clear = (state_q == ST_CHECK) || (state_q == ST_VCMP);
`else
      pk_clear = (state_q == ST_CHECK) || (state_q == ST_WRITE);
`endif
   end

   assign error              = error_q;
   assign bus.mem_address    = addr_q;
   assign bus.mem_byteenable = pk_be;
   assign bus.mem_writedata  = pk_word;
   assign bus.mem_clken      = 1'b1;
endmodule

// File: tb/tb_onchip_mem_stream_loader.sv
// Self-checking bench: vector table, stall/reset sequences and random loads vs a RAM image model.
module tb_onchip_mem_stream_loader;
   import onchip_loader_pkg::*;

`ifdef LOADER_READBACK_VERIFY_EN
   localparam int WCYC = 3;
`else
   localparam int WCYC = 1;
`endif

   typedef struct packed {
      logic [15:0] a;
      logic [31:0] d;
      logic [3:0]  be;
   } wr_t;

   typedef struct {
      logic [15:0] base;
      int          count;
      logic [7:0]  b0;
      logic        exp_err;
      int          exp_nw;
      logic [31:0] exp_last_d;
      logic [3:0]  exp_last_be;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] base_addr = '0;
   logic [17:0] byte_count = '0;
   logic        busy, done, error;
   int          n_cmp = 0;
   int          n_bad = 0;
   wr_t         wlog[$];
   logic [31:0] ram [0:MEM_DEPTH-1];
   logic        corrupt_en = 1'b0;

   onchip_mem_stream_loader_if #(.ADDR_W(16)) bus();

   onchip_mem_stream_loader dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .base_addr  (base_addr),
      .byte_count (byte_count),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   // RAM model: byte-enabled writes, registered reads, optional corruption at 0x0020.
   always @(posedge clk) begin
      if (bus.mem_chipselect && bus.mem_write) begin
         wlog.push_back('{a: bus.mem_address, d: bus.mem_writedata, be: bus.mem_byteenable});
         for (int k = 0; k < 4; k++)
            if (bus.mem_byteenable[k]) ram[bus.mem_address][8*k +: 8] <= bus.mem_writedata[8*k +: 8];
      end
      if (bus.mem_chipselect && !bus.mem_write)
         bus.mem_readdata <= ram[bus.mem_address] ^
                             ((corrupt_en && bus.mem_address == 16'h0020) ? 32'h0000FF00 : 32'h0);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic void mk_bytes(input logic [7:0] b0, input int c, output logic [7:0] q[$]);
      q = {};
      for (int i = 0; i < c; i++) q.push_back(8'(int'(b0) + i * 17));
   endfunction

   task automatic run_load(input logic [15:0] b, input int c, input logic [7:0] bytes[$],
                           input int gap_pct, input bit mid_start,
                           output bit got_done, output logic got_err, output int consumed,
                           output int lat, output int busy_low);
      int idx;
      idx = 0; got_done = 0; got_err = 1'b0; lat = -1; busy_low = 0;
      @(negedge clk);
      start = 1'b1; base_addr = b; byte_count = 18'(c);
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 0; cyc < 2000 && !got_done; cyc++) begin
         if (!busy) busy_low++;
         if (done) begin
            got_done = 1; got_err = error; lat = cyc;
         end
         start = mid_start && (cyc == 3);
         if (start) begin
            base_addr = 16'h1234; byte_count = 18'd4;
         end
         bus.st_valid = (idx < c) && (int'($urandom_range(99)) >= gap_pct);
         bus.st_data  = bus.st_valid ? bytes[idx] : 8'h00;
         if (bus.st_valid && bus.st_ready) idx++;
         @(negedge clk);
      end
      start = 1'b0;
      bus.st_valid = 1'b0;
      consumed = idx;
   endtask

   // Reference: expected word writes derived directly from base, count and byte list.
   task automatic check_load(input string tag, input logic [15:0] b, input int c,
                             input logic [7:0] bytes[$], input bit got_done, input logic got_err,
                             input int consumed, input int lat, input int busy_low, input bit timed);
      int  words;
      bit  exp_err;
      wr_t exp[$];
      wr_t w;
      words   = (c + 3) / 4;
      exp_err = (c > 0) && (int'(b) + words > MEM_DEPTH);
      if (!exp_err)
         for (int i = 0; i < words; i++) begin
            w.a = b + 16'(i); w.d = '0; w.be = '0;
            for (int k = 0; k < 4; k++)
               if (4 * i + k < c) begin
                  w.d[8*k +: 8] = bytes[4*i+k];
                  w.be[k]       = 1'b1;
               end
            exp.push_back(w);
         end
      chk({tag, " done"}, 64'(got_done), 64'd1);
      chk({tag, " error"}, 64'(got_err), 64'(exp_err));
      chk({tag, " consumed"}, 64'(consumed), 64'(exp_err ? 0 : c));
      chk({tag, " busy gaps"}, 64'(busy_low), 64'd0);
      if (timed)
         chk({tag, " latency"}, 64'(lat), 64'((exp_err || c == 0) ? 1 : c + words * WCYC + 1));
      chk({tag, " nwrites"}, 64'(wlog.size()), 64'(exp.size()));
      for (int i = 0; i < exp.size() && i < wlog.size(); i++)
         chk($sformatf("%s write%0d", tag, i), 64'(wlog[i]), 64'(exp[i]));
      chk({tag, " idle after"}, {62'd0, busy, done}, 64'd0);
   endtask

   initial begin
      vec_t        vecs[6];
      logic [7:0]  bytes[$];
      bit          gd;
      logic        ge;
      int          cons, lat, bl, n;
      logic [15:0] rb;
      int          rc, gap;

      vecs[0] = '{16'h0010, 8, 8'h11, 1'b0, 2, 32'h88776655, 4'hF};
      vecs[1] = '{16'h0000, 5, 8'hAA, 1'b0, 2, 32'h000000EE, 4'h1};
      vecs[2] = '{16'h0000, 0, 8'h00, 1'b0, 0, 32'h0, 4'h0};
      vecs[3] = '{16'd51199, 8, 8'h01, 1'b1, 0, 32'h0, 4'h0};
      vecs[4] = '{16'd51198, 8, 8'h01, 1'b0, 2, 32'h78675645, 4'hF};
      vecs[5] = '{16'd51199, 3, 8'h10, 1'b0, 1, 32'h00322110, 4'h7};

      bus.st_valid = 1'b0;
      bus.st_data  = 8'h00;
      repeat (3) @(negedge clk);
      chk("reset outputs", {6'd0, busy, done, error, bus.st_ready, bus.mem_chipselect, bus.mem_write,
          bus.mem_address, bus.mem_byteenable, bus.mem_writedata}, 64'd0);
      reset_n = 1'b1;
      @(negedge clk);
      chk("clken", 64'(bus.mem_clken), 64'd1);

      for (int v = 0; v < 6; v++) begin
         wlog.delete();
         mk_bytes(vecs[v].b0, vecs[v].count, bytes);
         run_load(vecs[v].base, vecs[v].count, bytes, 0, 1'b0, gd, ge, cons, lat, bl);
         chk($sformatf("vec%0d err", v), 64'(ge), 64'(vecs[v].exp_err));
         chk($sformatf("vec%0d nw", v), 64'(wlog.size()), 64'(vecs[v].exp_nw));
         if (vecs[v].exp_nw > 0 && wlog.size() > 0) begin
            chk($sformatf("vec%0d last data", v), 64'(wlog[wlog.size()-1].d), 64'(vecs[v].exp_last_d));
            chk($sformatf("vec%0d last be", v), 64'(wlog[wlog.size()-1].be), 64'(vecs[v].exp_last_be));
         end
         check_load($sformatf("vec%0d", v), vecs[v].base, vecs[v].count, bytes, gd, ge, cons, lat, bl, 1'b1);
      end

      // Stalled stream with a start pulse arriving mid-load.
      wlog.delete();
      mk_bytes(8'h11, 8, bytes);
      run_load(16'h0010, 8, bytes, 40, 1'b1, gd, ge, cons, lat, bl);
      check_load("stall", 16'h0010, 8, bytes, gd, ge, cons, lat, bl, 1'b0);
      repeat (2) @(negedge clk);
      chk("stall no restart", 64'(busy), 64'd0);

      // Reset after three bytes of a load.
      wlog.delete();
      @(negedge clk);
      start = 1'b1; base_addr = 16'h0200; byte_count = 18'd8;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      for (int cyc = 0; cyc < 50 && n < 3; cyc++) begin
         bus.st_valid = 1'b1;
         bus.st_data  = 8'(8'h51 + n);
         if (bus.st_ready) n++;
         @(negedge clk);
      end
      bus.st_valid = 1'b0;
      reset_n = 1'b0;
      @(negedge clk);
      chk("midreset outputs", {6'd0, busy, done, error, bus.st_ready, bus.mem_chipselect, bus.mem_write,
          bus.mem_address, bus.mem_byteenable, bus.mem_writedata}, 64'd0);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("midreset no write", 64'(wlog.size()), 64'd0);
      mk_bytes(8'hC1, 4, bytes);
      run_load(16'h0100, 4, bytes, 0, 1'b0, gd, ge, cons, lat, bl);
      check_load("after reset", 16'h0100, 4, bytes, gd, ge, cons, lat, bl, 1'b1);

      for (int r = 0; r < 10; r++) begin
         wlog.delete();
         rb  = (r % 3 == 0) ? 16'(MEM_DEPTH - int'($urandom_range(12))) : 16'($urandom_range(MEM_DEPTH - 64));
         rc  = int'($urandom_range(40));
         gap = (r % 2 == 0) ? 0 : 35;
         bytes = {};
         for (int i = 0; i < rc; i++) bytes.push_back(8'($urandom));
         run_load(rb, rc, bytes, gap, 1'b0, gd, ge, cons, lat, bl);
         check_load($sformatf("rand%0d", r), rb, rc, bytes, gd, ge, cons, lat, bl, gap == 0);
      end

`ifdef LOADER_READBACK_VERIFY_EN
      wlog.delete();
      corrupt_en = 1'b1;
      mk_bytes(8'h31, 8, bytes);
      run_load(16'h0020, 8, bytes, 0, 1'b0, gd, ge, cons, lat, bl);
      chk("verify done", 64'(gd), 64'd1);
      chk("verify error", 64'(ge), 64'd1);
      chk("verify latency", 64'(lat), 64'd8);
      chk("verify consumed", 64'(cons), 64'd4);
      chk("verify nwrites", 64'(wlog.size()), 64'd1);
      bus.st_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("verify st_ready%0d", i), 64'(bus.st_ready), 64'd0);
         @(negedge clk);
      end
      bus.st_valid = 1'b0;
      corrupt_en = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/onchip_mem_stream_loader.md
Name: onchip_mem_stream_loader

Overview:
- Upstream write-side feeder for the 32-bit single-port on-chip RAM (51200 words, 16-bit word address, byte enables, 1-cycle read latency).
- Accepts a byte stream (valid/ready), packs bytes little-endian into 32-bit words, and writes them to consecutive word addresses from a programmed base.
- Used to load program/data images into on-chip memory at run time.
- Drives the RAM's slave-port signals directly: address, byteenable, chipselect, write, writedata, clken, readdata.

Parameters:
- ADDR_W, 16, word-address width of the target RAM.
- DEPTH, 51200, number of 32-bit words in the target RAM; used for range checking.
- CNT_W, 18, width of byte_count (max 4*DEPTH bytes).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- start  in  1  one-cycle request to begin a load; honoured only in IDLE.
- base_addr  in  ADDR_W  first word address; latched on an accepted start.
- byte_count  in  CNT_W  number of bytes to load; latched on an accepted start.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse at the end of a load (success or error).
- error  out  1  sticky error status; cleared by the next accepted start.
- st_data  in  8  stream byte.
- st_valid  in  1  stream byte valid.
- st_ready  out  1  loader can accept a byte.
- mem_address  out  ADDR_W  RAM word address.
- mem_byteenable  out  4  RAM byte enables.
- mem_chipselect  out  1  RAM select.
- mem_write  out  1  RAM write strobe.
- mem_writedata  out  32  RAM write data.
- mem_clken  out  1  RAM clock enable; tied to 1.
- mem_readdata  in  32  RAM read data; valid 1 cycle after the address is presented.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - State goes to IDLE.
  - busy, done, error, st_ready, mem_chipselect, mem_write = 0.
  - mem_address, mem_byteenable, mem_writedata = 0; lane/word counters = 0.
  - Reset mid-load abandons the load; no further RAM writes are issued.
- FSM states: IDLE, CHECK, COLLECT, WRITE, FINISH (plus VRD and VCMP under the optional feature).
- IDLE:
  - start=1 latches base_addr and byte_count, clears error, goes to CHECK.
  - start while busy is ignored.
- CHECK (1 cycle):
  - words = ceil(byte_count/4), computed in CNT_W+1 bits.
  - byte_count==0 -> FINISH with no writes.
  - base_addr+words > DEPTH -> error=1, FINISH with no writes.
  - Otherwise -> COLLECT with lane=0 and word buffer cleared.
- COLLECT:
  - st_ready=1; a byte transfers when st_valid & st_ready.
  - The byte is placed in lane (byte index mod 4), bits [8*lane+7 : 8*lane], and its enable bit is set.
  - If lane==3 or it is the last byte -> WRITE. Otherwise lane increments.
  - Gaps in st_valid simply hold the state.
- WRITE (exactly 1 cycle):
  - st_ready=0; mem_chipselect=mem_write=1.
  - mem_byteenable = accumulated enables: 1111 for full words; partial final word 0001/0011/0111 for count mod 4 = 1/2/3.
  - Unfilled lanes of mem_writedata are 0.
  - Then word address increments. Bytes remaining -> COLLECT; none remaining -> FINISH.
- FINISH: done=1 for one cycle, busy=0 next cycle, return to IDLE.
- Sequencing and throughput:
  - busy is high in every state except IDLE. It is high in FINISH and drops the cycle after.
  - Peak throughput: 4 bytes per 5 cycles.
  - Address arithmetic never wraps, because the range check precedes any write.

Optional Feature:
- Macro: LOADER_READBACK_VERIFY_EN.
- Defined: after each WRITE, enter VRD, which presents the same address with chipselect=1, write=0. The next cycle, VCMP compares the enabled bytes of mem_readdata against the written data.
  - Mismatch -> error=1, FINISH; remaining stream bytes are not consumed.
  - Match -> continue as after WRITE.
  - Throughput becomes 4 bytes per 7 cycles.
- Undefined: VRD and VCMP do not exist; error is set only by the range check.

Decomposition:
- Shared package onchip_loader_pkg holds:
  - State enum, 3-bit encoding.
  - Constants MEM_DEPTH=51200, MEM_ADDR_W=16, MEM_DATA_W=32, MEM_BE_W=4.
- One natural sub-module: byte_word_packer, holding the lane counter, word buffer and enable accumulation, with load/clear/full outputs. The top level keeps the FSM, counters and memory interface.

Test Plan:
- Full words: start base=0x0010, count=8, bytes 11..88 -> writes 0x44332211 at 0x0010 and 0x88776655 at 0x0011, be=1111, then one done pulse, error=0.
- Partial tail: count=5, base=0, bytes AA..EE -> second write at 0x0001 with data 0x000000EE, be=0001.
- Empty and out-of-range loads:
  - count=0 -> done 2 cycles after start, no chipselect.
  - base=51199, count=8 -> error=1, done, no writes.
- Stalls and ignored start: random st_valid gaps plus a start pulse mid-load -> same RAM contents as the ungapped run, second start ignored, busy continuous.
- Reset mid-load: reset_n=0 after 3 bytes -> no write issued, all outputs 0, next load of 4 bytes at 0x0100 correct.
- Readback verify (LOADER_READBACK_VERIFY_EN): RAM model corrupts byte 1 of the word at 0x0020 -> error=1 and done after VCMP, st_ready stays 0 afterwards.
